// File: rtl/movavg_pkg.sv
// Shared defaults and width helpers for the moving-average adder tree.
package movavg_pkg;

    localparam int WL_DEF    = 64;
    localparam int LOG2N_DEF = 2;
    localparam int AVG_DEF   = 1;

    // Window length N for a given log2 size.
    function automatic int taps_n(input int log2n);
        return 1 << log2n;
    endfunction

    // Width of tree level j: one extra carry bit per pairwise add.
    function automatic int lvl_w(input int wl, input int j);
        return wl + j;
    endfunction

endpackage

// File: rtl/movavg_if.sv
// Sample stream in, windowed sum/average out.
interface movavg_if
    import movavg_pkg::*;
#(
    parameter int WL    = WL_DEF,
    parameter int LOG2N = LOG2N_DEF
);
    logic [WL-1:0]       din;
    logic                din_valid;
    logic                clear;
    logic [WL-1:0]       dout;
    logic [WL+LOG2N-1:0] dsum;
    logic                dout_valid;
    logic                dout_primed;

    modport master (
        output din, din_valid, clear,
        input  dout, dsum, dout_valid, dout_primed
    );

    modport slave (
        input  din, din_valid, clear,
        output dout, dsum, dout_valid, dout_primed
    );
endinterface

// File: rtl/movavg_addlvl.sv
// One registered adder-tree level: pairwise sums plus valid/primed tracking.
module movavg_addlvl
    import movavg_pkg::*;
#(
    parameter int NIN = 4,
    parameter int IW  = WL_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     kill,
    input  logic                     vld_in,
    input  logic                     prm_in,
    input  logic [NIN-1:0][IW-1:0]   din,
    output logic                     vld_out,
    output logic                     prm_out,
    output logic [NIN/2-1:0][IW:0]   dout
);
    logic [NIN/2-1:0][IW:0] sum;
    logic                   load;

    for (genvar i = 0; i < NIN/2; i++) begin : g_add
        assign sum[i] = {1'b0, din[2*i]} + {1'b0, din[2*i+1]};
    end

    // A killed entry must not disturb the held data either.
    assign load = vld_in & ~kill;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_out <= 1'b0;
            prm_out <= 1'b0;
            dout    <= '0;
        end else begin
            vld_out <= load;
            prm_out <= prm_in & ~kill;
            if (load) dout <= sum;
        end
    end
endmodule

// File: rtl/movavg_tree.sv
// N-tap moving sum/average with delay line, fill tracking and registered log2 adder tree.
module movavg_tree
    import movavg_pkg::*;
#(
    parameter int WL    = WL_DEF,
    parameter int LOG2N = LOG2N_DEF,
    parameter int AVG   = AVG_DEF
) (
    input  logic     clk,
    input  logic     reset,
    movavg_if.slave  bus
);
    localparam int N    = taps_n(LOG2N);
    localparam int SUMW = lvl_w(WL, LOG2N);

    logic [N-1:1][WL-1:0] tap;
    logic [LOG2N-1:0]     fill;
    logic [LOG2N:0]       vld_pipe;
    logic [LOG2N:0]       prm_pipe;

    always_ff @(posedge clk) begin
        if (reset) begin
            tap  <= '0;
            fill <= '0;
        end else if (bus.clear) begin
            tap  <= '0;
            fill <= '0;
            if (bus.din_valid) begin
                tap[1] <= bus.din;
                fill   <= LOG2N'(1);
            end
        end else if (bus.din_valid) begin
            tap[1] <= bus.din;
            for (int k = 2; k < N; k++) tap[k] <= tap[k-1];
            if (fill != LOG2N'(N-1)) fill <= fill + LOG2N'(1);
        end
    end

    assign vld_pipe[0] = bus.din_valid;
    assign prm_pipe[0] = bus.din_valid & ~bus.clear & (fill == LOG2N'(N-1));

    for (genvar j = 0; j <= LOG2N; j++) begin : g_lvl
        logic [(N>>j)-1:0][lvl_w(WL, j)-1:0] lv;

        if (j == 0) begin : g_ops
            // A clearing sample starts a fresh window, so old taps read as zero.
            always_comb begin
                lv    = '0;
                lv[0] = bus.din;
                for (int k = 1; k < N; k++) lv[k] = bus.clear ? '0 : tap[k];
            end
        end else begin : g_add
            logic kill;
            // The first level carries the sample being accepted now, which clear must keep.
            assign kill = (j == 1) ? 1'b0 : bus.clear;

            movavg_addlvl #(
                .NIN (N >> (j-1)),
                .IW  (lvl_w(WL, j-1))
            ) u_lvl (
                .clk     (clk),
                .reset   (reset),
                .kill    (kill),
                .vld_in  (vld_pipe[j-1]),
                .prm_in  (prm_pipe[j-1]),
                .din     (g_lvl[j-1].lv),
                .vld_out (vld_pipe[j]),
                .prm_out (prm_pipe[j]),
                .dout    (lv)
            );
        end
    end

    assign bus.dsum        = g_lvl[LOG2N].lv[0];
    assign bus.dout_valid  = vld_pipe[LOG2N];
    assign bus.dout_primed = prm_pipe[LOG2N];
    assign bus.dout        = (AVG != 0) ? bus.dsum[SUMW-1:LOG2N] : bus.dsum[WL-1:0];
endmodule

// File: tb/tb_movavg_tree.sv
// Scoreboard bench: three configurations, window model predicts every strobe.
module tb_movavg_tree;

    typedef struct {
        int           cyc;
        logic [127:0] sum;
        logic         primed;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    sb_t          q[3][$];
    logic [63:0]  win[2][$];
    int           cnt[2];
    logic [127:0] last_s[3];
    logic [127:0] last_o[3];
    string        nm[3] = '{"A", "B", "C"};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    movavg_if #(.WL(64), .LOG2N(2)) ifa ();
    movavg_if #(.WL(64), .LOG2N(2)) ifb ();
    movavg_if #(.WL(16), .LOG2N(3)) ifc ();

    movavg_tree #(.WL(64), .LOG2N(2), .AVG(1)) dut_a (.clk(clk), .reset(rst), .bus(ifa));
    movavg_tree #(.WL(64), .LOG2N(2), .AVG(0)) dut_b (.clk(clk), .reset(rst), .bus(ifb));
    movavg_tree #(.WL(16), .LOG2N(3), .AVG(1)) dut_c (.clk(clk), .reset(rst), .bus(ifc));

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drop predictions that would emerge after the current edge.
    function automatic void flush(input int id);
        sb_t keep[$];
        foreach (q[id][i]) if (q[id][i].cyc <= cyc) keep.push_back(q[id][i]);
        q[id] = keep;
    endfunction

    function automatic void model(input int m, input logic [63:0] d, input bit clr, input bit vld);
        int           lg = (m == 1) ? 3 : 2;
        int           n  = 1 << lg;
        sb_t          e;
        logic [127:0] s = '0;
        if (clr) begin
            win[m].delete();
            cnt[m] = 0;
            if (m == 0) begin flush(0); flush(1); end else flush(2);
        end
        if (vld) begin
            e.primed = (cnt[m] >= n - 1);
            win[m].push_front(d);
            if (win[m].size() > n) void'(win[m].pop_back());
            if (cnt[m] < n - 1) cnt[m]++;
            foreach (win[m][i]) s += 128'(win[m][i]);
            e.sum = s;
            e.cyc = cyc + lg;
            if (m == 0) begin q[0].push_back(e); q[1].push_back(e); end
            else q[2].push_back(e);
        end
    endfunction

    task automatic zero_inputs();
        ifa.din = '0; ifa.din_valid = 1'b0; ifa.clear = 1'b0;
        ifb.din = '0; ifb.din_valid = 1'b0; ifb.clear = 1'b0;
        ifc.din = '0; ifc.din_valid = 1'b0; ifc.clear = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #2;
            zero_inputs();
        end
    endtask

    task automatic drv_ab(input bit v, input logic [63:0] d, input bit c);
        @(posedge clk); #2;
        zero_inputs();
        ifa.din = d; ifa.din_valid = v; ifa.clear = c;
        ifb.din = d; ifb.din_valid = v; ifb.clear = c;
        model(0, d, c, v);
    endtask

    task automatic drv_c(input bit v, input logic [15:0] d, input bit c);
        @(posedge clk); #2;
        zero_inputs();
        ifc.din = d; ifc.din_valid = v; ifc.clear = c;
        model(1, 64'(d), c, v);
    endtask

    task automatic do_reset();
        @(posedge clk); #2;
        zero_inputs();
        rst = 1'b1;
        model(0, '0, 1'b1, 1'b0);
        model(1, '0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic mon(input int id, input logic v, input logic p,
                       input logic [127:0] s, input logic [127:0] o);
        int           lg  = (id == 2) ? 3 : 2;
        int           wl  = (id == 2) ? 16 : 64;
        bit           avg = (id != 1);
        sb_t          e;
        logic [127:0] eo;
        if (v === 1'b1) begin
            if (q[id].size() == 0) begin
                chk({nm[id], " spurious strobe"}, 128'(v), 128'(0));
            end else begin
                e  = q[id].pop_front();
                eo = (avg ? (e.sum >> lg) : e.sum) & ((128'(1) << wl) - 1);
                chk({nm[id], " latency"}, 128'(cyc), 128'(e.cyc));
                chk({nm[id], " dsum"}, s, e.sum);
                chk({nm[id], " dout"}, o, eo);
                chk({nm[id], " primed"}, 128'(p), 128'(e.primed));
            end
        end else begin
            if (q[id].size() > 0 && q[id][0].cyc <= cyc) begin
                chk({nm[id], " missing strobe"}, 128'(v), 128'(1));
                void'(q[id].pop_front());
            end
            if (!rst) begin
                chk({nm[id], " dsum hold"}, s, last_s[id]);
                chk({nm[id], " dout hold"}, o, last_o[id]);
            end
        end
        last_s[id] = s;
        last_o[id] = o;
    endtask

    always @(negedge clk) begin
        mon(0, ifa.dout_valid, ifa.dout_primed, 128'(ifa.dsum), 128'(ifa.dout));
        mon(1, ifb.dout_valid, ifb.dout_primed, 128'(ifb.dsum), 128'(ifb.dout));
        mon(2, ifc.dout_valid, ifc.dout_primed, 128'(ifc.dsum), 128'(ifc.dout));
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        zero_inputs();
        cnt[0] = 0; cnt[1] = 0;
        foreach (last_s[i]) begin last_s[i] = '0; last_o[i] = '0; end
        repeat (3) @(posedge clk);
        #2 rst = 1'b0;

        // Idle after reset: everything stays zero.
        repeat (10) begin
            idle(1);
            @(negedge clk);
            chk("A reset dout", 128'(ifa.dout), 128'(0));
            chk("A reset dsum", 128'(ifa.dsum), 128'(0));
            chk("A reset valid", 128'(ifa.dout_valid), 128'(0));
            chk("A reset primed", 128'(ifa.dout_primed), 128'(0));
            chk("C reset dsum", 128'(ifc.dsum), 128'(0));
        end

        // Back-to-back 1..5.
        for (int i = 1; i <= 5; i++) drv_ab(1'b1, 64'(i), 1'b0);
        idle(4);
        chk("A final dsum 2+3+4+5", 128'(ifa.dsum), 128'(14));
        chk("A final avg", 128'(ifa.dout), 128'(3));

        // Same data with bubbles after a flush.
        drv_ab(1'b0, '0, 1'b1);
        drv_ab(1'b1, 64'd1, 1'b0); idle(1);
        drv_ab(1'b1, 64'd2, 1'b0); idle(2);
        drv_ab(1'b1, 64'd3, 1'b0); idle(1);
        drv_ab(1'b1, 64'd4, 1'b0);
        drv_ab(1'b1, 64'd5, 1'b0);
        idle(4);
        chk("A bubbled final dsum", 128'(ifa.dsum), 128'(14));

        // All-ones boundary: full-precision sum, average and wrapped sum.
        drv_ab(1'b0, '0, 1'b1);
        repeat (4) drv_ab(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
        idle(4);
        chk("A max dsum", 128'(ifa.dsum), 128'h3_FFFF_FFFF_FFFF_FFFC);
        chk("A max avg", 128'(ifa.dout), 128'hFFFF_FFFF_FFFF_FFFF);
        chk("B max wrap", 128'(ifb.dout), 128'hFFFF_FFFF_FFFF_FFFC);

        // Clear with a sample while results are in flight.
        drv_ab(1'b0, '0, 1'b1);
        drv_ab(1'b1, 64'd10, 1'b0);
        drv_ab(1'b1, 64'd20, 1'b0);
        drv_ab(1'b1, 64'd30, 1'b0);
        drv_ab(1'b1, 64'd40, 1'b0);
        drv_ab(1'b1, 64'd7, 1'b1);
        drv_ab(1'b1, 64'd1, 1'b0);
        drv_ab(1'b1, 64'd2, 1'b0);
        drv_ab(1'b1, 64'd3, 1'b0);
        idle(4);
        chk("A post-clear dsum", 128'(ifa.dsum), 128'(13));

        // Eight-tap instance, then reset kills the pending ninth result.
        for (int i = 1; i <= 9; i++) drv_c(1'b1, 16'(i), 1'b0);
        idle(1);
        do_reset();
        idle(6);
        chk("C post-reset dsum", 128'(ifc.dsum), 128'(0));
        chk("C post-reset dout", 128'(ifc.dout), 128'(0));
        chk("A post-reset dsum", 128'(ifa.dsum), 128'(0));
        chk("A pending after run", 128'(q[0].size()), 128'(0));
        chk("B pending after run", 128'(q[1].size()), 128'(0));
        chk("C pending after run", 128'(q[2].size()), 128'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
